// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmit path between two byte clients. After reset the
//   block writes two configuration bytes. It then arbitrates client requests
//   round-robin. For each granted byte it polls the UART status register
//   until the transmit queue has room, and then writes the byte.
//
// Ports
//   clk, reset              single clock; asynchronous active-high reset
//   req_valid[1:0]          per-client request, bit i = client i
//   req_data[15:0]          client i byte on [8i+7:8i]
//   req_ready[1:0]          one-cycle acceptance pulse for the granted client
//   uart_re / uart_we       UART register read / write enables (never both)
//   uart_regsel[2:0]        UART register select
//   uart_din[31:0]          UART write data
//   uart_dout[31:0]         UART read data; bit 15 = tx_queue_full
//   init_done               high from the first IDLE cycle until reset
//   timeout_err             one-cycle pulse when a byte is dropped
//
// Parameters: CFG_A, CFG_B (init bytes), TIMEOUT (poll limit).
// Optional feature: define UART_SCHED_TIMEOUT_EN to drop a byte after
// TIMEOUT consecutive full polls. Without it, POLL waits indefinitely.
//
// state  | meaning
// INIT_A | write CFG_A into regsel 2, din[23:16]
// INIT_B | write CFG_B into regsel 3, din[31:24]
// IDLE   | no UART access; grant a waiting client
// POLL   | read status (regsel 5) until tx_queue_full clears
// WRITE  | write latched byte to regsel 0, pulse req_ready

module uart_tx_scheduler #(
    parameter logic [7:0] CFG_A   = 8'h00,
    parameter logic [7:0] CFG_B   = 8'h00,
    parameter int         TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    output logic [1:0]  req_ready,
    output logic        uart_re,
    output logic        uart_we,
    output logic [2:0]  uart_regsel,
    output logic [31:0] uart_din,
    input  logic [31:0] uart_dout,
    output logic        init_done,
    output logic        timeout_err
);

    typedef enum logic [2:0] {INIT_A, INIT_B, IDLE, POLL, WRITE} state_t;

    state_t     state, state_nxt;
    logic       rr, rr_nxt;
    logic       idx, idx_nxt;
    logic [7:0] data_q, data_nxt;
    logic       tx_full;

    logic unused_dout;
    assign tx_full     = uart_dout[15];
    assign unused_dout = ^{uart_dout[31:16], uart_dout[14:0]};

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] poll_cnt, poll_cnt_nxt;
    logic          timeout_q, timeout_nxt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT_A;
            rr        <= 1'b0;
            idx       <= 1'b0;
            data_q    <= 8'h00;
            init_done <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
            poll_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            rr     <= rr_nxt;
            idx    <= idx_nxt;
            data_q <= data_nxt;
            if (state == INIT_B)
                init_done <= 1'b1;
`ifdef UART_SCHED_TIMEOUT_EN
            poll_cnt  <= poll_cnt_nxt;
            timeout_q <= timeout_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        rr_nxt      = rr;
        idx_nxt     = idx;
        data_nxt    = data_q;
        uart_re     = 1'b0;
        uart_we     = 1'b0;
        uart_regsel = 3'd0;
        uart_din    = 32'h0000_0000;
        req_ready   = 2'b00;
`ifdef UART_SCHED_TIMEOUT_EN
        poll_cnt_nxt = poll_cnt;
        timeout_nxt  = 1'b0;
        timeout_err  = 1'b0;
`endif

        case (state)
            INIT_A: begin
                uart_we     = 1'b1;
                uart_regsel = 3'd2;
                uart_din    = {8'h00, CFG_A, 16'h0000};
                state_nxt   = INIT_B;
            end
            INIT_B: begin
                uart_we     = 1'b1;
                uart_regsel = 3'd3;
                uart_din    = {CFG_B, 24'h00_0000};
                state_nxt   = IDLE;
            end
            IDLE: begin
`ifdef UART_SCHED_TIMEOUT_EN
                // The dropped byte is acknowledged here, one cycle after the
                // final full poll, so the client can move on.
                if (timeout_q) begin
                    req_ready[idx] = 1'b1;
                    timeout_err    = 1'b1;
                end
`endif
                if (req_valid != 2'b00) begin
                    idx_nxt   = (req_valid == 2'b11) ? rr : req_valid[1];
                    data_nxt  = idx_nxt ? req_data[15:8] : req_data[7:0];
                    state_nxt = POLL;
`ifdef UART_SCHED_TIMEOUT_EN
                    poll_cnt_nxt = CW'(TIMEOUT - 1);
`endif
                end
            end
            POLL: begin
                uart_re     = 1'b1;
                uart_regsel = 3'd5;
                if (!tx_full) begin
                    state_nxt = WRITE;
`ifdef UART_SCHED_TIMEOUT_EN
                end else if (poll_cnt == '0) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                    rr_nxt      = ~idx;
                end else begin
                    poll_cnt_nxt = poll_cnt - 1'b1;
`endif
                end
            end
            WRITE: begin
                uart_we        = 1'b1;
                uart_regsel    = 3'd0;
                uart_din       = {24'h00_0000, data_q};
                req_ready[idx] = 1'b1;
                rr_nxt         = ~idx;
                state_nxt      = IDLE;
            end
            default: state_nxt = INIT_A;
        endcase

        // While reset holds, the state stays at INIT_A. Mask the bus so that
        // nothing is written until reset is released.
        if (reset) begin
            uart_re     = 1'b0;
            uart_we     = 1'b0;
            uart_regsel = 3'd0;
            uart_din    = 32'h0000_0000;
            req_ready   = 2'b00;
`ifdef UART_SCHED_TIMEOUT_EN
            timeout_err = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    localparam logic [7:0] CFG_A   = 8'hA5;
    localparam logic [7:0] CFG_B   = 8'h3C;
    localparam int         TIMEOUT = 16;

    localparam int K_IDLE  = 0;
    localparam int K_POLL  = 1;
    localparam int K_WRITE = 2;
    localparam int K_OTHER = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_data = 16'h0000;
    logic [1:0]  req_ready;
    logic        uart_re, uart_we;
    logic [2:0]  uart_regsel;
    logic [31:0] uart_din, uart_dout;
    logic        init_done, timeout_err;
    logic        tx_full = 1'b0;
    logic [31:0] noise = 32'h0;

    int n_chk = 0;
    int n_fail = 0;

    // model state
    int         prev_kind = K_IDLE;
    int         last_kind = K_IDLE;
    logic       rr_m = 1'b0;
    logic       exp_client = 1'b0;
    logic [7:0] exp_byte = 8'h00;
    int         poll_run = 0;
    int         cyc = 0;
    int         n_writes = 0;
    logic [7:0] wr_log[$];
    int         wr_time[$];

    always #5 clk = ~clk;

    // UART register file model: only the status register returns tx_full,
    // and the other bits carry noise.
    assign uart_dout = (uart_regsel == 3'd5) ? {noise[31:16], tx_full, noise[14:0]} : 32'h0;

    uart_tx_scheduler #(.CFG_A(CFG_A), .CFG_B(CFG_B), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .uart_re(uart_re), .uart_we(uart_we), .uart_regsel(uart_regsel),
        .uart_din(uart_din), .uart_dout(uart_dout),
        .init_done(init_done), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int kind_of();
        if (uart_re) return K_POLL;
        if (uart_we) return (uart_regsel == 3'd0) ? K_WRITE : K_OTHER;
        return K_IDLE;
    endfunction

    // One clock, sampled at the falling edge. The inputs present now are the
    // inputs that the DUT used at the last rising edge.
    task automatic cycle();
        int k;
        @(negedge clk);
        cyc++;
        k = kind_of();
        chk("re_we_excl", 32'(uart_re & uart_we), 32'd0);
        chk("init_done_hold", 32'(init_done), 32'd1);
        case (k)
            K_POLL: begin
                chk("poll_regsel", 32'(uart_regsel), 32'd5);
                chk("poll_din", uart_din, 32'd0);
                chk("poll_ready", 32'(req_ready), 32'd0);
                chk("poll_terr", 32'(timeout_err), 32'd0);
                if (prev_kind == K_IDLE) begin
                    chk("grant_has_req", 32'(req_valid != 2'b00), 32'd1);
                    exp_client = (req_valid == 2'b11) ? rr_m : req_valid[1];
                    exp_byte   = exp_client ? req_data[15:8] : req_data[7:0];
                    poll_run   = 1;
                end else begin
                    chk("poll_repeat_full", 32'(prev_kind == K_POLL && tx_full), 32'd1);
                    poll_run++;
                end
`ifdef UART_SCHED_TIMEOUT_EN
                chk("poll_bound", 32'(poll_run <= TIMEOUT), 32'd1);
`endif
            end
            K_WRITE: begin
                chk("wr_after_free_poll", 32'(prev_kind == K_POLL && !tx_full), 32'd1);
                chk("wr_din", uart_din, {24'h0, exp_byte});
                chk("wr_ready", 32'(req_ready), exp_client ? 32'd2 : 32'd1);
                chk("wr_terr", 32'(timeout_err), 32'd0);
                rr_m = ~exp_client;
                n_writes++;
                wr_log.push_back(uart_din[7:0]);
                wr_time.push_back(cyc);
            end
            K_IDLE: begin
                chk("idle_regsel", 32'(uart_regsel), 32'd0);
                chk("idle_din", uart_din, 32'd0);
                chk("idle_no_stall", 32'(prev_kind == K_IDLE && req_valid != 2'b00), 32'd0);
`ifdef UART_SCHED_TIMEOUT_EN
                if (prev_kind == K_POLL) begin
                    chk("to_run", 32'(poll_run), 32'(TIMEOUT));
                    chk("to_full", 32'(tx_full), 32'd1);
                    chk("to_ready", 32'(req_ready), exp_client ? 32'd2 : 32'd1);
                    chk("to_err", 32'(timeout_err), 32'd1);
                    rr_m = ~exp_client;
                end else begin
                    chk("idle_ready", 32'(req_ready), 32'd0);
                    chk("idle_terr", 32'(timeout_err), 32'd0);
                end
`else
                chk("idle_after_poll", 32'(prev_kind == K_POLL), 32'd0);
                chk("idle_ready", 32'(req_ready), 32'd0);
                chk("idle_terr", 32'(timeout_err), 32'd0);
`endif
            end
            default: chk("stray_write_regsel", 32'(uart_regsel), 32'd0);
        endcase
        prev_kind = k;
        last_kind = k;
        if (req_ready[0]) req_valid[0] = 1'b0;
        if (req_ready[1]) req_valid[1] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("rst_we", 32'(uart_we), 32'd0);
        chk("rst_re", 32'(uart_re), 32'd0);
        chk("rst_regsel", 32'(uart_regsel), 32'd0);
        chk("rst_din", uart_din, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_hold_we", 32'(uart_we), 32'd0);
        reset = 1'b0;
        #1;
        chk("inita_we", 32'(uart_we), 32'd1);
        chk("inita_re", 32'(uart_re), 32'd0);
        chk("inita_regsel", 32'(uart_regsel), 32'd2);
        chk("inita_din", uart_din, 32'h00A5_0000);
        chk("inita_done", 32'(init_done), 32'd0);
        @(negedge clk);
        chk("initb_we", 32'(uart_we), 32'd1);
        chk("initb_regsel", 32'(uart_regsel), 32'd3);
        chk("initb_din", uart_din, 32'h3C00_0000);
        chk("initb_done", 32'(init_done), 32'd0);
        @(negedge clk);
        chk("c3_init_done", 32'(init_done), 32'd1);
        chk("c3_idle_we", 32'(uart_we), 32'd0);
        chk("c3_idle_re", 32'(uart_re), 32'd0);
        prev_kind = K_IDLE;
        rr_m      = 1'b0;
        poll_run  = 0;
        wr_log.delete();
        wr_time.delete();
    endtask

    initial begin
        int npoll;
        int nbad;
        int wr_base;

        // single byte from client 0
        do_reset();
        tx_full = 1'b0;
        req_data[7:0] = 8'h41;
        req_valid = 2'b01;
        cycle();
        chk("d032_poll", 32'(last_kind), 32'(K_POLL));
        cycle();
        chk("d032_write", 32'(last_kind), 32'(K_WRITE));
        chk("d032_din", uart_din, 32'h0000_0041);
        chk("d032_ready", 32'(req_ready), 32'd1);
        cycle();
        chk("d032_idle", 32'(last_kind), 32'(K_IDLE));

        // both clients held valid: alternating, one write every 3 cycles
        do_reset();
        req_data = 16'h2211;
        req_valid = 2'b11;
        repeat (12) begin
            cycle();
            req_valid = 2'b11;
        end
        chk("d033_nwr", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < wr_log.size())
                chk("d033_byte", 32'(wr_log[i]), (i % 2 == 0) ? 32'h11 : 32'h22);
        for (int i = 1; i < 4; i++)
            if (i < wr_time.size())
                chk("d033_gap", 32'(wr_time[i] - wr_time[i-1]), 32'd3);

`ifndef UART_SCHED_TIMEOUT_EN
        // long full stall
        do_reset();
        req_data[15:8] = 8'h77;
        req_valid = 2'b10;
        tx_full = 1'b1;
        npoll = 0;
        nbad = 0;
        repeat (50) begin
            cycle();
            if (last_kind == K_POLL) npoll++;
            if (req_ready != 2'b00 || uart_we) nbad++;
        end
        chk("d034_polls", 32'(npoll), 32'd50);
        chk("d034_no_we_ready", 32'(nbad), 32'd0);
        tx_full = 1'b0;
        cycle();
        chk("d034_write", 32'(last_kind), 32'(K_WRITE));
        chk("d034_din", uart_din, 32'h0000_0077);
        chk("d034_ready", 32'(req_ready), 32'd2);
`else
        // full stuck: byte dropped after TIMEOUT polls, other client next
        do_reset();
        req_data = 16'h2211;
        req_valid = 2'b11;
        tx_full = 1'b1;
        npoll = 0;
        nbad = 0;
        repeat (TIMEOUT) begin
            cycle();
            if (last_kind == K_POLL) npoll++;
            if (req_ready != 2'b00 || uart_we || timeout_err) nbad++;
        end
        chk("d035_polls", 32'(npoll), 32'(TIMEOUT));
        chk("d035_quiet", 32'(nbad), 32'd0);
        cycle();
        chk("d035_terr", 32'(timeout_err), 32'd1);
        chk("d035_ready", 32'(req_ready), 32'd1);
        chk("d035_no_we", 32'(uart_we), 32'd0);
        req_valid = 2'b11;
        req_data[7:0] = 8'h33;
        tx_full = 1'b0;
        cycle();
        cycle();
        chk("d035_next_write", 32'(last_kind), 32'(K_WRITE));
        chk("d035_next_din", uart_din, 32'h0000_0022);
        chk("d035_next_ready", 32'(req_ready), 32'd2);
        cycle();
        tx_full = 1'b0;
        repeat (3) cycle();
`endif

        // reset while polling discards the byte
        do_reset();
        req_data[7:0] = 8'h5A;
        req_valid = 2'b01;
        tx_full = 1'b1;
        repeat (3) cycle();
        chk("d036_in_poll", 32'(last_kind), 32'(K_POLL));
        do_reset();
        tx_full = 1'b0;
        wr_base = n_writes;
        repeat (4) cycle();
        chk("d036_discarded", 32'(n_writes - wr_base), 32'd0);

        // randomized traffic against the rule model
        do_reset();
        wr_base = n_writes;
        for (int n = 0; n < 600; n++) begin
            cycle();
            if ($urandom_range(0, 249) == 0) do_reset();
            for (int c = 0; c < 2; c++)
                if (!req_valid[c] && $urandom_range(0, 2) == 0) begin
                    req_valid[c] = 1'b1;
                    req_data[8*c +: 8] = 8'($urandom);
                end
            tx_full = ($urandom_range(0, 3) == 0);
            noise = $urandom;
        end
        chk("rand_progress", 32'(n_writes - wr_base > 40), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter CFG_A, 8'h00, config A byte written at init (divisor[7:3], tx-empty/rx-full/parity IRQ enables [2:0]).
REQ-002 Parameter CFG_B, 8'h00, config B byte written at init (parity type, data bits, double stop, stop-bit IRQ enable).
REQ-003 Parameter TIMEOUT, 1024, poll-cycle limit before a byte is dropped (used only with UART_SCHED_TIMEOUT_EN).
REQ-004 Port clk  in  1  single clock, rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port req_valid  in  2  per-client byte request, bit i = client i.
REQ-007 Port req_data  in  16  client i byte on [8i+7:8i].
REQ-008 Port req_ready  out  2  one-cycle acceptance pulse, bit i = client i.
REQ-009 Port uart_re  out  1  UART register read enable.
REQ-010 Port uart_we  out  1  UART register write enable.
REQ-011 Port uart_regsel  out  3  UART register select.
REQ-012 Port uart_din  out  32  UART write data.
REQ-013 Port uart_dout  in  32  UART read data, combinational from regsel.
REQ-014 Port init_done  out  1  high once both config writes completed.
REQ-015 Port timeout_err  out  1  one-cycle pulse when a byte is dropped.

Function
REQ-016 FSM states SHALL be INIT_A, INIT_B, IDLE, POLL, WRITE; all outputs SHALL be decoded from state and latched registers only.
REQ-017 INIT_A: uart_we=1, regsel=2, uart_din[23:16]=CFG_A, other din bits 0; unconditionally -> INIT_B.
REQ-018 INIT_B: uart_we=1, regsel=3, uart_din[31:24]=CFG_B, other bits 0; unconditionally -> IDLE; init_done SHALL be 1 from first IDLE cycle until reset.
REQ-019 IDLE: no UART access; if any req_valid, grant one client, latch its index and byte, -> POLL; else stay.
REQ-020 Arbitration SHALL be round-robin: both valid -> grant pointer rr; one valid -> that client; rr SHALL become the non-served client on each WRITE.
REQ-021 POLL: uart_re=1, regsel=5; uart_dout[15] (tx_queue_full)=0 -> WRITE, =1 -> stay in POLL.
REQ-022 WRITE: uart_we=1, regsel=0, uart_din[7:0]=latched byte, other bits 0; req_ready[granted]=1 for exactly this cycle; -> IDLE.
REQ-023 Minimum service time SHALL be 3 cycles per byte (IDLE, POLL, WRITE); back-to-back bytes from alternating clients SHALL sustain that rate.
REQ-024 Clients SHALL hold req_valid/req_data stable until req_ready; a granted byte SHALL be sent even if req_valid drops after grant.
REQ-025 uart_re and uart_we SHALL never be high in the same cycle; idle outputs SHALL be re=0, we=0, regsel=0, din=0.

Reset
REQ-026 reset SHALL force state INIT_A asynchronously; rr=0, init_done=0, req_ready=0, timeout_err=0, latched byte/index=0.
REQ-027 In the INIT_A cycle following reset release, uart_we=1, uart_regsel=2 and uart_din[23:16]=CFG_A per REQ-017; during reset assertion uart_re=0, uart_we=0, regsel=0, din=0.
REQ-028 Reset mid-operation SHALL discard any pending byte without a req_ready pulse and SHALL rerun INIT_A/INIT_B.

Configuration
REQ-029 Macro UART_SCHED_TIMEOUT_EN defined: a POLL-cycle counter (clog2(TIMEOUT) bits, cleared on POLL entry) SHALL, when tx_queue_full persists for TIMEOUT cycles, go to IDLE without a UART write, pulse req_ready[granted] and timeout_err for one cycle, and advance rr.
REQ-030 Macro undefined: no counter; POLL waits indefinitely; timeout_err SHALL be tied 0.

Verification
REQ-031 Reset release, CFG_A=8'hA5, CFG_B=8'h3C -> cycle 1 we=1 regsel=2 din=32'h00A50000; cycle 2 we=1 regsel=3 din=32'h3C000000; init_done=1 in cycle 3.
REQ-032 Client 0 sends 8'h41, uart_dout[15]=0 -> POLL one cycle, then we=1 regsel=0 din=32'h00000041 with req_ready=2'b01 in same cycle.
REQ-033 Both clients valid continuously (8'h11, 8'h22) -> writes alternate 11,22,11,22, one every 3 cycles, starting with client 0.
REQ-034 tx_queue_full held 1 for 50 cycles -> 50 POLL cycles, no we, no req_ready; full drops -> WRITE next cycle.
REQ-035 With UART_SCHED_TIMEOUT_EN, TIMEOUT=16, full stuck -> after 16 POLL cycles timeout_err and req_ready pulse once, no regsel=0 write, next client served.
REQ-036 reset asserted during POLL -> outputs idle immediately, no req_ready, INIT_A/INIT_B rerun after release.
